// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back inputs, ID read ports and debug outputs.
interface wb_regfile_if #(
  parameter int instruction_width = 32,
  parameter int register_addr     = 5
);
  logic                         mem_to_reg_pip3;
  logic                         reg_w_pip3;
  logic [instruction_width-1:0] y_pip2;
  logic [instruction_width-1:0] d_out_pip;
  logic [register_addr-1:0]     wb_addr_pip2;
  logic [register_addr-1:0]     ra_addr;
  logic [register_addr-1:0]     rb_addr;
  logic [instruction_width-1:0] ra_data;
  logic [instruction_width-1:0] rb_data;
  logic [instruction_width-1:0] wb_data;
  logic                         wb_valid;
  logic [31:0]                  wb_count;

  // Pipeline side: presents MEM/WB results and read indices, consumes read data.
  modport master (
    output mem_to_reg_pip3, reg_w_pip3, y_pip2, d_out_pip, wb_addr_pip2,
           ra_addr, rb_addr,
    input  ra_data, rb_data, wb_data, wb_valid, wb_count
  );

  // Register file side.
  modport slave (
    input  mem_to_reg_pip3, reg_w_pip3, y_pip2, d_out_pip, wb_addr_pip2,
           ra_addr, rb_addr,
    output ra_data, rb_data, wb_data, wb_valid, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file with
// write-through bypass on both ID read ports and a committed-write counter.
module wb_regfile #(
  parameter int instruction_width   = 32,
  parameter int register_addr       = 5,
  parameter int register_file_depth = 2**register_addr
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  localparam int unsigned DEPTH = register_file_depth;

  logic [instruction_width-1:0] regs_q [DEPTH];
  logic [31:0]                  count_q;
  logic [31:0]                  count_d;
  logic [instruction_width-1:0] wb_data_d;
  logic                         wb_valid_d;
  logic [instruction_width-1:0] ra_data_d;
  logic [instruction_width-1:0] rb_data_d;

  // Write-back mux and commit qualifier; index 0 and reset both suppress the commit.
  always_comb begin
    wb_data_d  = bus.mem_to_reg_pip3 ? bus.d_out_pip : bus.y_pip2;
    wb_valid_d = bus.reg_w_pip3 && (bus.wb_addr_pip2 != '0) && !rst;
  end

  // Read ports: x0 and reset read zero, otherwise bypass the committing value.
  always_comb begin
    ra_data_d = '0;
    rb_data_d = '0;
    if (!rst) begin
      if (bus.ra_addr == '0)
        ra_data_d = '0;
      else if (wb_valid_d && (bus.ra_addr == bus.wb_addr_pip2))
        ra_data_d = wb_data_d;
      else
        ra_data_d = regs_q[bus.ra_addr];

      if (bus.rb_addr == '0)
        rb_data_d = '0;
      else if (wb_valid_d && (bus.rb_addr == bus.wb_addr_pip2))
        rb_data_d = wb_data_d;
      else
        rb_data_d = regs_q[bus.rb_addr];
    end
  end

  // Next committed-write count; wraps naturally at 32 bits.
  always_comb begin
    count_d = count_q;
    if (wb_valid_d)
      count_d = count_q + 32'd1;
  end

  // Register storage; x0 is never written because wb_valid excludes index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
    end else if (wb_valid_d) begin
      regs_q[bus.wb_addr_pip2] <= wb_data_d;
    end
  end

  // Debug counter of committed writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  // Drive the interface outputs.
  always_comb begin
    bus.wb_data  = wb_data_d;
    bus.wb_valid = wb_valid_d;
    bus.ra_data  = ra_data_d;
    bus.rb_data  = rb_data_d;
    bus.wb_count = count_q;
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver pushes expected outputs computed
// from an array-based register model; the monitor compares at each falling edge.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_regfile_if #(.instruction_width(32), .register_addr(5)) bus ();

  wb_regfile #(
    .instruction_width  (32),
    .register_addr      (5),
    .register_file_depth(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] wd;
    logic        wv;
    logic [31:0] cnt;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mregs [32];
  logic [31:0] mcnt;
  int          total = 0;
  int          bad   = 0;

  // Reference model --------------------------------------------------------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mcnt = 32'h0;
  endtask

  function automatic logic [31:0] m_wd();
    return bus.mem_to_reg_pip3 ? bus.d_out_pip : bus.y_pip2;
  endfunction

  function automatic logic m_wv();
    return bus.reg_w_pip3 && (bus.wb_addr_pip2 != 5'd0) && !rst;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (m_wv() && a == bus.wb_addr_pip2) return m_wd();
    return mregs[a];
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.ra  = m_read(bus.ra_addr);
    e.rb  = m_read(bus.rb_addr);
    e.wd  = m_wd();
    e.wv  = m_wv();
    e.cnt = mcnt;
    expq.push_back(e);
  endtask

  // Model of the edge: commit the pending write when it is valid.
  task automatic model_edge();
    if (m_wv()) begin
      mregs[bus.wb_addr_pip2] = m_wd();
      mcnt = mcnt + 32'd1;
    end
  endtask

  task automatic apply(input logic m2r, input logic rw, input logic [31:0] y,
                       input logic [31:0] d, input logic [4:0] wa,
                       input logic [4:0] ra, input logic [4:0] rb);
    bus.mem_to_reg_pip3 = m2r;
    bus.reg_w_pip3      = rw;
    bus.y_pip2          = y;
    bus.d_out_pip       = d;
    bus.wb_addr_pip2    = wa;
    bus.ra_addr         = ra;
    bus.rb_addr         = rb;
  endtask

  // One cycle: drive, predict, then advance past the edge.
  task automatic step(input string tag, input logic m2r, input logic rw,
                      input logic [31:0] y, input logic [31:0] d,
                      input logic [4:0] wa, input logic [4:0] ra, input logic [4:0] rb);
    apply(m2r, rw, y, d, wa, ra, rb);
    push_exp(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor ----------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check({e.tag, ".ra_data"},  bus.ra_data,  e.ra);
        check({e.tag, ".rb_data"},  bus.rb_data,  e.rb);
        check({e.tag, ".wb_data"},  bus.wb_data,  e.wd);
        check({e.tag, ".wb_valid"}, {31'h0, bus.wb_valid}, {31'h0, e.wv});
        check({e.tag, ".wb_count"}, bus.wb_count, e.cnt);
      end
    end
  end

  // Stimulus ---------------------------------------------------------------
  initial begin
    int wait_cycles;
    model_reset();
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Reset state, with a write attempt that must not land.
    @(posedge clk); #1;
    step("reset_state", 1'b0, 1'b1, 32'hCAFE_0001, 32'h0, 5'd5, 5'd5, 5'd31);
    #2 rst = 1'b0;

    // ALU write-back to x5, then read from storage.
    step("alu_bypass", 1'b0, 1'b1, 32'h1234_5678, 32'h0, 5'd5, 5'd5, 5'd0);
    step("alu_read",   1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);

    // Load write-back to x31.
    step("load_wb",   1'b1, 1'b1, 32'h1, 32'hDEAD_BEEF, 5'd31, 5'd31, 5'd5);
    step("load_read", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd5);

    // Bypass on both ports over an older stored value.
    step("byp_pre",  1'b0, 1'b1, 32'h11, 32'h0, 5'd7, 5'd0, 5'd0);
    step("byp_both", 1'b0, 1'b1, 32'h22, 32'h0, 5'd7, 5'd7, 5'd7);
    step("byp_post", 1'b0, 1'b0, 32'h55, 32'h66, 5'd7, 5'd7, 5'd7);

    // Write to x0 is dropped.
    step("x0_write", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    step("x0_read",  1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7);

    // Write to a different index than the one being read.
    step("byp_other", 1'b0, 1'b1, 32'h77, 32'h0, 5'd8, 5'd7, 5'd8);

    // Randomized traffic; small index range half of the time to hit bypasses.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa, ra, rb;
      if ($urandom_range(0, 1) == 0) begin
        wa = 5'($urandom_range(0, 5));
        ra = 5'($urandom_range(0, 5));
        rb = 5'($urandom_range(0, 5));
      end else begin
        wa = 5'($urandom_range(0, 31));
        ra = 5'($urandom_range(0, 31));
        rb = 5'($urandom_range(0, 31));
      end
      step("random", 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
           $urandom, $urandom, wa, ra, rb);
    end

    // Known values before the async reset test.
    step("pre_rst_w5",  1'b0, 1'b1, 32'hA5A5_0005, 32'h0, 5'd5, 5'd0, 5'd0);
    step("pre_rst_w31", 1'b0, 1'b1, 32'hA5A5_001F, 32'h0, 5'd31, 5'd5, 5'd0);

    // Asynchronous reset mid-cycle, no clock edge before the sample.
    apply(1'b0, 1'b1, 32'h4444, 32'h0, 5'd5, 5'd5, 5'd31);
    #1 rst = 1'b1;
    model_reset();
    push_exp("async_rst");
    @(posedge clk); #1;
    step("rst_hold", 1'b0, 1'b1, 32'h4444, 32'h0, 5'd5, 5'd5, 5'd31);
    #2 rst = 1'b0;
    step("rst_rel_read", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);

    // Counter wrap via backdoor preload of the count register.
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
    force dut.count_q = 32'hFFFF_FFFF;
    mcnt = 32'hFFFF_FFFF;
    push_exp("cnt_preload");
    @(negedge clk); #1;
    release dut.count_q;
    @(posedge clk); #1;
    step("cnt_last", 1'b0, 1'b1, 32'hABC, 32'h0, 5'd9, 5'd9, 5'd0);
    step("cnt_wrap", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);

    // Reset coincident with a pending write to x3: the write is lost.
    apply(1'b0, 1'b1, 32'h99, 32'h0, 5'd3, 5'd3, 5'd9);
    push_exp("race_pre");
    @(posedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    step("race_rst", 1'b0, 1'b1, 32'h99, 32'h0, 5'd3, 5'd3, 5'd9);
    #2 rst = 1'b0;
    step("race_read", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd9);

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (expq.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (expq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the 5-stage pipeline CPU. It consumes the MEM/WB pipeline register outputs, selects the write-back data (ALU result or load data) and commits it to a 32-entry register file. It serves the two ID-stage read ports with write-through bypass. It also exports the write-back value for EX forwarding and keeps a committed-write counter for debug.

## Interface
Parameters:
- instruction_width, 32, data/register width
- register_addr, 5, register index width
- register_file_depth, 2**register_addr, number of registers

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- mem_to_reg_pip3  in  1  1: write back load data; 0: write back ALU result
- reg_w_pip3  in  1  register write enable from MEM/WB
- y_pip2  in  instruction_width  ALU result from MEM/WB
- d_out_pip  in  instruction_width  load data from MEM/WB
- wb_addr_pip2  in  register_addr  destination register index
- ra_addr  in  register_addr  ID read port A index
- rb_addr  in  register_addr  ID read port B index
- ra_data  out  instruction_width  read port A data (combinational)
- rb_data  out  instruction_width  read port B data (combinational)
- wb_data  out  instruction_width  selected write-back value (combinational), used for EX forwarding
- wb_valid  out  1  committed write this cycle: reg_w_pip3 & (wb_addr_pip2 != 0) & ~rst
- wb_count  out  32  count of committed writes

## Operation
- Write-back mux: wb_data = mem_to_reg_pip3 ? d_out_pip : y_pip2. The mux is always active, independent of reg_w_pip3.
- Commit: at a rising clk, if wb_valid = 1, then regs[wb_addr_pip2] <= wb_data.
- Register 0 is hardwired to zero. Writes to index 0 are dropped: no storage change and no count increment.
- Reads: ra_data = regs[ra_addr], except when the bypass condition below holds. rb_data follows the same rule with rb_addr.
- Bypass: if wb_valid = 1 and ra_addr == wb_addr_pip2, then ra_data = wb_data in the same cycle. rb_data uses the same rule. Both ports may bypass at once.
- With the bypass, ID sees the value being written back this cycle, so no stall or forward is needed for a producer 3 instructions earlier.
- Index 0 always reads 0, including when wb_addr_pip2 = 0 with reg_w_pip3 = 1.
- wb_count increments by 1 on every rising clk where wb_valid = 1. It wraps from 0xFFFFFFFF to 0.
- There is no stall or flush input. A bubble arrives as reg_w_pip3 = 0.

## Timing
- Reset (rst = 1, asynchronous, takes effect immediately without waiting for clk):
  - all register_file_depth registers clear to 0;
  - wb_count = 0;
  - wb_valid = 0;
  - ra_data = 0 and rb_data = 0, with bypass suppressed;
  - wb_data still follows the mux.
- Reset mid-operation: rst asserted on the same edge as a pending write wins. The write is lost and the count is not incremented.
- Reset release: rst deasserting between edges allows a commit on the next rising clk.
- Write latency: a value presented at edge N is readable from storage after edge N. It is visible on ra_data/rb_data during cycle N-1..N via the bypass.
- Read latency: 0 cycles, combinational from ra_addr/rb_addr and the MEM/WB inputs.
- Back-to-back writes to the same index: the last write wins. Each committed write counts separately.
- Simultaneous bypass and write to a different index: the read returns the stored value, and the write lands on the edge.

## Test plan
- Reset: preload regs via writes, assert rst asynchronously mid-cycle -> ra_data = rb_data = 0 and wb_count = 0 immediately; after release, reading x5 returns 0.
- ALU write-back: reg_w = 1, mem_to_reg = 0, y_pip2 = 0x1234_5678, wb_addr = 5 for one edge -> next cycle ra_addr = 5 reads 0x1234_5678, wb_count = 1.
- Load write-back: mem_to_reg = 1, d_out_pip = 0xDEAD_BEEF, y_pip2 = 0x1, wb_addr = 31 -> x31 = 0xDEAD_BEEF.
- Bypass: x7 = 0x11, then reg_w = 1, wb_addr = 7, y = 0x22, ra_addr = rb_addr = 7 -> before the edge both read 0x22 and wb_valid = 1; after the edge with reg_w = 0 both read 0x22.
- x0 protection: reg_w = 1, wb_addr = 0, y = 0xFFFF_FFFF, ra_addr = 0 -> ra_data = 0 before and after the edge, wb_valid = 0, wb_count unchanged.
- Counter wrap and reset race: force wb_count to 0xFFFF_FFFF with 2^32-1 writes (or a bench backdoor), commit once -> wb_count = 0. Then assert rst coincident with a write to x3 = 0x99 -> x3 = 0, wb_count = 0.
